// File: rtl/bus_bridge_cmd_master.sv
// bus_bridge_cmd_master
//   Remote-side command engine of the UART bus bridge. Frames decoded by the UART receiver
//   are queued in a small FIFO and replayed one at a time on a parallel master request bus.
//   Read data, or zero after a timed-out read, is returned to the UART transmitter.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   u_rx_ready/data    one-cycle frame strobe and frame {mode, wdata, addr} from the receiver
//   u_tx_busy          transmitter busy
//   u_tx_data/en       returned read byte and its one-cycle transmit strobe
//   m_req/mode/addr/   bus request (held until m_done or timeout), direction, address and
//   m_wdata            write data
//   m_done/m_rdata     one-cycle completion pulse and read data valid with it
//   fifo_count         frames currently buffered
//   overflow           sticky: a frame was dropped because the FIFO was full
//   timeout_err        sticky: a transaction timed out
module bus_bridge_cmd_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned FRAME_WIDTH    = DATA_WIDTH + ADDR_WIDTH + 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          u_rx_ready,
  input  logic [FRAME_WIDTH-1:0]        u_rx_data,
  input  logic                          u_tx_busy,
  output logic [DATA_WIDTH-1:0]         u_tx_data,
  output logic                          u_tx_en,
  output logic                          m_req,
  output logic                          m_mode,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  input  logic                          m_done,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TmoEn = (TIMEOUT_CYCLES != 0);
  // Counter value during the last permitted REQ cycle.
  localparam logic [TmoW-1:0] TmoLast = TmoEn ? TmoW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {StIdle, StReq, StTxWait, StTxStrobe, StTxGap} state_e;

  state_e                  r_state;
  logic [FRAME_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;
  logic                    r_overflow;
  logic                    r_timeout_err;
  logic [TmoW-1:0]         r_tmo;
  logic                    r_m_req;
  logic                    r_m_mode;
  logic [ADDR_WIDTH-1:0]   r_m_addr;
  logic [DATA_WIDTH-1:0]   r_m_wdata;
  logic                    r_tx_en;
  logic [DATA_WIDTH-1:0]   r_tx_data;

  logic                    w_pop;
  logic                    w_full;
  logic                    w_push;
  logic                    w_tmo_hit;
  logic [FRAME_WIDTH-1:0]  w_head;

  assign w_pop     = (r_state == StIdle) && (r_count != '0);
  assign w_full    = (r_count == CntW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push    = u_rx_ready && (!w_full || w_pop);
  assign w_tmo_hit = TmoEn && (r_tmo == TmoLast);
  assign w_head    = r_mem[r_rptr];

  // Frame storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= u_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (u_rx_ready && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= StIdle;
      r_tmo         <= '0;
      r_timeout_err <= 1'b0;
      r_m_req       <= 1'b0;
      r_m_mode      <= 1'b0;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= '0;
    end else begin
      r_tx_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_m_mode  <= w_head[FRAME_WIDTH-1];
            r_m_addr  <= w_head[ADDR_WIDTH-1:0];
            r_m_wdata <= w_head[ADDR_WIDTH +: DATA_WIDTH];
            r_m_req   <= 1'b1;
            r_tmo     <= '0;
            r_state   <= StReq;
          end
        end
        StReq: begin
          // m_done wins over an expiring counter.
          if (m_done) begin
            r_m_req <= 1'b0;
            r_tmo   <= '0;
            if (r_m_mode) begin
              r_state <= StIdle;
            end else begin
              r_tx_data <= m_rdata;
              r_state   <= StTxWait;
            end
          end else if (w_tmo_hit) begin
            r_m_req       <= 1'b0;
            r_tmo         <= '0;
            r_timeout_err <= 1'b1;
            if (r_m_mode) begin
              r_state <= StIdle;
            end else begin
              // Still answer a timed-out read so the far side never hangs.
              r_tx_data <= '0;
              r_state   <= StTxWait;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StTxWait: begin
          if (!u_tx_busy) begin
            r_tx_en <= 1'b1;
            r_state <= StTxStrobe;
          end
        end
        StTxStrobe: r_state <= StTxGap;
        // Gap cycle lets the transmitter raise busy before the next strobe can be considered.
        StTxGap:    r_state <= StIdle;
        default:    r_state <= StIdle;
      endcase
    end
  end

  assign u_tx_data   = r_tx_data;
  assign u_tx_en     = r_tx_en;
  assign m_req       = r_m_req;
  assign m_mode      = r_m_mode;
  assign m_addr      = r_m_addr;
  assign m_wdata     = r_m_wdata;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_bridge_cmd_master.sv
// tb_bus_bridge_cmd_master
//   Self-checking bench for bus_bridge_cmd_master (TIMEOUT_CYCLES = 16). Every cycle the DUT
//   outputs are compared with a transaction-level reference model; a vector table and a few
//   directed sequences add explicit expectations for the corner cases.
module tb_bus_bridge_cmd_master;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int FW    = DW + AW + 1;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   u_rx_ready;
  logic [FW-1:0]          u_rx_data;
  logic                   u_tx_busy;
  logic [DW-1:0]          u_tx_data;
  logic                   u_tx_en;
  logic                   m_req;
  logic                   m_mode;
  logic [AW-1:0]          m_addr;
  logic [DW-1:0]          m_wdata;
  logic                   m_done;
  logic [DW-1:0]          m_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   timeout_err;

  always #5 clk = ~clk;

  bus_bridge_cmd_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .u_rx_ready (u_rx_ready),
    .u_rx_data  (u_rx_data),
    .u_tx_busy  (u_tx_busy),
    .u_tx_data  (u_tx_data),
    .u_tx_en    (u_tx_en),
    .m_req      (m_req),
    .m_mode     (m_mode),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_done     (m_done),
    .m_rdata    (m_rdata),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted frames, the frame on the bus, and the return path.
  logic [FW-1:0] mdl_q[$];
  logic [FW-1:0] mdl_cur;
  bit            mdl_act;    // transaction on the bus
  int            mdl_age;    // cycles the current request has been visible
  bit            mdl_wait;   // read byte waiting for the transmitter to go idle
  int            mdl_ret;    // 2: strobe cycle, 1: gap cycle, 0: nothing
  logic [DW-1:0] mdl_tx;
  bit            mdl_ovf;
  bit            mdl_terr;

  // Observation helpers filled in by step().
  int            n_strobe;
  logic [DW-1:0] last_tx;
  logic [DW-1:0] tx_log[$];
  logic [AW-1:0] starts[$];
  int            peak;
  int            hi;
  logic          prev_req;

  function automatic logic [FW-1:0] frm(bit w, logic [DW-1:0] wd, logic [AW-1:0] a);
    return {w, wd, a};
  endfunction

  function automatic bit mdl_idle();
    return !mdl_act && !mdl_wait && mdl_ret == 0 && mdl_q.size() == 0;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    mdl_cur  = '0;
    mdl_act  = 0;
    mdl_age  = 0;
    mdl_wait = 0;
    mdl_ret  = 0;
    mdl_tx   = '0;
    mdl_ovf  = 0;
    mdl_terr = 0;
  endtask

  // One clock edge of the model, using the inputs presented during the preceding cycle.
  task automatic model_edge();
    bit pop;
    pop = !mdl_act && !mdl_wait && mdl_ret == 0 && mdl_q.size() > 0;
    if (mdl_ret > 0) mdl_ret--;
    else if (mdl_wait && !u_tx_busy) begin
      mdl_wait = 0;
      mdl_ret  = 2;
    end
    if (mdl_act) begin
      if (m_done || mdl_age == TMO) begin
        if (!m_done) mdl_terr = 1;
        mdl_act = 0;
        if (!mdl_cur[FW-1]) begin
          mdl_tx   = m_done ? m_rdata : '0;
          mdl_wait = 1;
        end
      end else begin
        mdl_age++;
      end
    end
    if (pop) begin
      mdl_cur = mdl_q.pop_front();
      mdl_act = 1;
      mdl_age = 1;
    end
    if (u_rx_ready) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(u_rx_data);
      else mdl_ovf = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge();
    #1;
    chk("m_req",       32'(m_req),       32'(mdl_act));
    chk("m_mode",      32'(m_mode),      32'(mdl_cur[FW-1]));
    chk("m_addr",      32'(m_addr),      32'(mdl_cur[AW-1:0]));
    chk("m_wdata",     32'(m_wdata),     32'(mdl_cur[AW+DW-1:AW]));
    chk("u_tx_en",     32'(u_tx_en),     32'(mdl_ret == 2));
    chk("u_tx_data",   32'(u_tx_data),   32'(mdl_tx));
    chk("fifo_count",  32'(fifo_count),  32'(mdl_q.size()));
    chk("overflow",    32'(overflow),    32'(mdl_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(mdl_terr));
    if (u_tx_en) begin
      n_strobe++;
      last_tx = u_tx_data;
      tx_log.push_back(u_tx_data);
    end
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (m_req) hi++;
    if (m_req && !prev_req) starts.push_back(m_addr);
    prev_req   = m_req;
    u_rx_ready = 1'b0;
    m_done     = 1'b0;
  endtask

  task automatic push(logic [FW-1:0] f);
    u_rx_ready = 1'b1;
    u_rx_data  = f;
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  // Answers each request in its first cycle until the engine is idle; reads return addr ^ 0x96.
  task automatic drain();
    int n;
    n = 0;
    while (!mdl_idle() && n < 300) begin
      if (m_req) begin
        m_done  = 1'b1;
        m_rdata = m_addr[DW-1:0] ^ 8'h96;
      end
      step();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain: engine still busy after %0d cycles, want idle", n);
    end
  endtask

  typedef struct {
    bit            rx;
    logic [FW-1:0] d;
    bit            done;
    logic [DW-1:0] rd;
    bit            busy;
    bit            req;
    bit            mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            en;
    logic [DW-1:0] txd;
    int            cnt;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit rx, logic [FW-1:0] d, bit done, logic [DW-1:0] rd, bit busy,
                              bit req, bit mode, logic [AW-1:0] addr, logic [DW-1:0] wd,
                              bit en, logic [DW-1:0] txd, int cnt);
    vec_t v;
    v.rx = rx;  v.d = d;       v.done = done; v.rd = rd;   v.busy = busy;
    v.req = req; v.mode = mode; v.addr = addr; v.wd = wd;  v.en = en;
    v.txd = txd; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    logic [FW-1:0] w_a5;
    logic [FW-1:0] r_45;
    w_a5 = frm(1'b1, 8'hA5, 12'h123);
    r_45 = frm(1'b0, 8'h00, 12'h045);
    //            rx    frame  done  rdata  busy | req   mode  addr     wdata  en    txdata cnt
    tbl[0]  = mk(1'b1, w_a5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1);
    tbl[1]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[2]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[3]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[4]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[5]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[6]  = mk(1'b0, '0,   1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 0);
    tbl[7]  = mk(1'b1, r_45, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h123, 8'hA5, 1'b0, 8'h00, 1);
    tbl[8]  = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h045, 8'h00, 1'b0, 8'h00, 0);
    tbl[9]  = mk(1'b0, '0,   1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 12'h045, 8'h00, 1'b0, 8'h3C, 0);
    tbl[10] = mk(1'b0, '0,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 12'h045, 8'h00, 1'b0, 8'h3C, 0);
    tbl[11] = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h045, 8'h00, 1'b1, 8'h3C, 0);
    tbl[12] = mk(1'b0, '0,   1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 12'h045, 8'h00, 1'b0, 8'h3C, 0);
    tbl[13] = mk(1'b0, '0,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'h045, 8'h00, 1'b0, 8'h3C, 0);

    rstn       = 1'b0;
    u_rx_ready = 1'b0;
    u_rx_data  = '0;
    u_tx_busy  = 1'b0;
    m_done     = 1'b0;
    m_rdata    = '0;
    prev_req   = 1'b0;
    n_strobe   = 0;
    peak       = 0;
    hi         = 0;
    last_tx    = '0;
    model_reset();
    step();
    step();
    rstn = 1'b1;
    chk("reset_m_req", 32'(m_req), 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);

    // Single write followed by single read, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      u_rx_ready = tbl[i].rx;
      u_rx_data  = tbl[i].d;
      m_done     = tbl[i].done;
      m_rdata    = tbl[i].rd;
      u_tx_busy  = tbl[i].busy;
      step();
      chk($sformatf("tbl%0d_m_req", i),   32'(m_req),      32'(tbl[i].req));
      chk($sformatf("tbl%0d_m_mode", i),  32'(m_mode),     32'(tbl[i].mode));
      chk($sformatf("tbl%0d_m_addr", i),  32'(m_addr),     32'(tbl[i].addr));
      chk($sformatf("tbl%0d_m_wdata", i), 32'(m_wdata),    32'(tbl[i].wd));
      chk($sformatf("tbl%0d_tx_en", i),   32'(u_tx_en),    32'(tbl[i].en));
      chk($sformatf("tbl%0d_tx_data", i), 32'(u_tx_data),  32'(tbl[i].txd));
      chk($sformatf("tbl%0d_count", i),   32'(fifo_count), 32'(tbl[i].cnt));
    end
    u_tx_busy = 1'b0;

    // Strobe held off while the transmitter stays busy for 20 cycles.
    push(frm(1'b0, 8'h00, 12'h0AB));
    step();
    m_done    = 1'b1;
    m_rdata   = 8'h5A;
    u_tx_busy = 1'b1;
    step();
    n_strobe = 0;
    repeat (20) step();
    chk("busy_hold_no_strobe", 32'(n_strobe), 32'd0);
    u_tx_busy = 1'b0;
    repeat (4) step();
    chk("busy_hold_strobes", 32'(n_strobe), 32'd1);
    chk("busy_hold_data", 32'(last_tx), 32'h5A);

    // Back-to-back frames while the first request is stalled.
    peak     = 0;
    n_strobe = 0;
    tx_log.delete();
    starts.delete();
    push(frm(1'b1, 8'h11, 12'h001));
    push(frm(1'b0, 8'h22, 12'h002));
    push(frm(1'b1, 8'h33, 12'h003));
    push(frm(1'b0, 8'h44, 12'h004));
    repeat (3) step();
    chk("b2b_peak", 32'(peak), 32'd3);
    drain();
    chk("b2b_strobes", 32'(n_strobe), 32'd2);
    chk("b2b_starts", 32'(starts.size()), 32'd4);
    if (tx_log.size() == 2) begin
      chk("b2b_tx0", 32'(tx_log[0]), 32'h94);
      chk("b2b_tx1", 32'(tx_log[1]), 32'h92);
    end

    // Overflow: 1 in flight, 4 buffered, 6th dropped; then push coinciding with a pop.
    starts.delete();
    for (int i = 1; i <= 6; i++) push(frm(1'b1, 8'(i), 12'(12'h100 + i)));
    chk("ovf_count_full", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    m_done = 1'b1;
    step();
    push(frm(1'b1, 8'hEE, 12'h1F0));
    chk("ovf_push_on_pop_count", 32'(fifo_count), 32'd4);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_starts", 32'(starts.size()), 32'd6);
    if (starts.size() == 6) chk("ovf_last_addr", 32'(starts[5]), 32'h1F0);

    // Read that never completes: request held exactly TMO cycles, zero byte returned.
    push(frm(1'b0, 8'h00, 12'h333));
    hi       = 0;
    n_strobe = 0;
    repeat (40) step();
    chk("tmo_req_cycles", 32'(hi), 32'(TMO));
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_strobes", 32'(n_strobe), 32'd1);
    chk("tmo_data", 32'(last_tx), 32'h00);

    // m_done on the expiry cycle is a success.
    do_reset();
    push(frm(1'b0, 8'h00, 12'h334));
    hi       = 0;
    n_strobe = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_req && hi == TMO) begin
        m_done  = 1'b1;
        m_rdata = 8'hC7;
      end
      step();
    end
    chk("expiry_req_cycles", 32'(hi), 32'(TMO));
    chk("expiry_no_err", 32'(timeout_err), 32'd0);
    chk("expiry_strobes", 32'(n_strobe), 32'd1);
    chk("expiry_data", 32'(last_tx), 32'hC7);

    // Reset while in REQ, then while waiting on the transmitter.
    push(frm(1'b0, 8'h00, 12'h250));
    step();
    do_reset();
    chk("rst_req_m_req", 32'(m_req), 32'd0);
    chk("rst_req_addr", 32'(m_addr), 32'd0);
    n_strobe = 0;
    repeat (10) step();
    chk("rst_req_no_strobe", 32'(n_strobe), 32'd0);
    push(frm(1'b0, 8'h00, 12'h251));
    step();
    m_done    = 1'b1;
    m_rdata   = 8'h77;
    u_tx_busy = 1'b1;
    step();
    do_reset();
    chk("rst_txw_tx_data", 32'(u_tx_data), 32'd0);
    chk("rst_txw_count", 32'(fifo_count), 32'd0);
    u_tx_busy = 1'b0;
    repeat (10) step();
    chk("rst_txw_no_strobe", 32'(n_strobe), 32'd0);
    starts.delete();
    push(frm(1'b1, 8'h5E, 12'h2AA));
    drain();
    chk("post_rst_starts", 32'(starts.size()), 32'd1);
    if (starts.size() == 1) chk("post_rst_addr", 32'(starts[0]), 32'h2AA);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      u_rx_ready = ($urandom_range(0, 3) == 0);
      u_rx_data  = frm(1'($urandom_range(0, 1)), 8'($urandom), 12'($urandom));
      m_done     = ($urandom_range(0, 5) == 0);
      m_rdata    = 8'($urandom);
      u_tx_busy  = ($urandom_range(0, 2) == 0);
      rstn       = ($urandom_range(0, 499) != 0);
      step();
    end
    rstn      = 1'b1;
    u_tx_busy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
